// File: rtl/uart_cmd_ctrl_if.sv
// UART FIFO and register-bus signals of the command controller.
// master = controller side, slave = UART FIFOs / register file side.
interface uart_cmd_ctrl_if;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_err;

  modport master (
    input  rx_empty, r_data, tx_full, reg_rdata,
    output rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_err
  );

  modport slave (
    output rx_empty, r_data, tx_full, reg_rdata,
    input  rd_uart, w_data, wr_uart, reg_addr, reg_wdata, reg_wr, reg_rd, busy, frame_err
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// UART command parser: 'W' addr data -> register write, 'K'; 'R' addr -> register read, data; else '?'.
// Latency: 4 cycles (write) / 5 cycles (read) from byte available to wr_uart; all outputs registered.
// Backpressure: holds in SEND while tx_full; inter-byte timeout only with UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic             clk,
  input logic             reset,
  uart_cmd_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND
  } state_t;

  state_t     state_q, state_nx;
  logic       wr_flag_q, wr_flag_nx;
  logic [7:0] resp_q, resp_nx;
  logic       rd_uart_q, rd_uart_nx;
  logic       wr_uart_q, wr_uart_nx;
  logic [7:0] w_data_q, w_data_nx;
  logic [7:0] reg_addr_q, reg_addr_nx;
  logic [7:0] reg_wdata_q, reg_wdata_nx;
  logic       reg_wr_q, reg_wr_nx;
  logic       reg_rd_q, reg_rd_nx;
  logic       busy_q;
  logic       frame_err_q, frame_err_nx;
  logic       take;

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > (1 << 20))) begin : g_bad_timeout
    $error("uart_cmd_ctrl: TIMEOUT_CYCLES must be within 2..2^20");
  end

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_nx;
`endif

  // rd_uart_q blocks a second pop while the FIFO head is still being removed
  assign take = ((state_q == IDLE) || (state_q == GET_ADDR) || (state_q == GET_DATA)) &&
                !bus.rx_empty && !rd_uart_q;

  always_comb begin
    state_nx     = state_q;
    wr_flag_nx   = wr_flag_q;
    resp_nx      = resp_q;
    rd_uart_nx   = 1'b0;
    wr_uart_nx   = 1'b0;
    w_data_nx    = w_data_q;
    reg_addr_nx  = reg_addr_q;
    reg_wdata_nx = reg_wdata_q;
    reg_wr_nx    = 1'b0;
    reg_rd_nx    = 1'b0;
    frame_err_nx = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
    cnt_nx       = '0;
`endif
    if (take) rd_uart_nx = 1'b1;

    case (state_q)
      IDLE: if (take) begin
        if (bus.r_data == 8'h57) begin
          state_nx   = GET_ADDR;
          wr_flag_nx = 1'b1;
        end else if (bus.r_data == 8'h52) begin
          state_nx   = GET_ADDR;
          wr_flag_nx = 1'b0;
        end else begin
          state_nx = SEND;
          resp_nx  = 8'h3F;
        end
      end
      GET_ADDR: if (take) begin
        reg_addr_nx = bus.r_data;
        state_nx    = wr_flag_q ? GET_DATA : BUS_RD;
      end
      GET_DATA: if (take) begin
        reg_wdata_nx = bus.r_data;
        state_nx     = BUS_WR;
      end
      BUS_WR: begin
        reg_wr_nx = 1'b1;
        resp_nx   = 8'h4B;
        state_nx  = SEND;
      end
      BUS_RD: begin
        reg_rd_nx = 1'b1;
        state_nx  = RD_WAIT;
      end
      RD_WAIT: begin
        resp_nx  = bus.reg_rdata;
        state_nx = SEND;
      end
      SEND: if (!bus.tx_full && !wr_uart_q) begin
        w_data_nx  = resp_q;
        wr_uart_nx = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase

`ifdef UART_CMD_TIMEOUT_EN
    // a partial frame is dropped silently apart from the frame_err pulse
    if ((state_q == GET_ADDR) || (state_q == GET_DATA)) begin
      if (take) begin
        cnt_nx = '0;
      end else if (cnt_q == TO_LAST) begin
        state_nx     = IDLE;
        frame_err_nx = 1'b1;
      end else begin
        cnt_nx = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_flag_q   <= 1'b0;
      resp_q      <= 8'h00;
      rd_uart_q   <= 1'b0;
      wr_uart_q   <= 1'b0;
      w_data_q    <= 8'h00;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_nx;
      wr_flag_q   <= wr_flag_nx;
      resp_q      <= resp_nx;
      rd_uart_q   <= rd_uart_nx;
      wr_uart_q   <= wr_uart_nx;
      w_data_q    <= w_data_nx;
      reg_addr_q  <= reg_addr_nx;
      reg_wdata_q <= reg_wdata_nx;
      reg_wr_q    <= reg_wr_nx;
      reg_rd_q    <= reg_rd_nx;
      busy_q      <= (state_nx != IDLE);
      frame_err_q <= frame_err_nx;
`ifdef UART_CMD_TIMEOUT_EN
      cnt_q       <= cnt_nx;
`endif
    end
  end

  assign bus.rd_uart   = rd_uart_q;
  assign bus.wr_uart   = wr_uart_q;
  assign bus.w_data    = w_data_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: FIFO/register-file models, frame table, corner sequences, random frames.
module tb_uart_cmd_ctrl;
`ifdef UART_CMD_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 100000;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if bus ();
  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  // receive FIFO contents (written by stimulus), register file, transmit log (written by monitor)
  logic [7:0] rx_mem [0:2047];
  int         wp;
  int         rp;
  bit   [7:0] mem [0:255];
  logic [7:0] txlog [0:1023];
  int         tx_cnt, rdu_cnt, regwr_cnt, regrd_cnt, ferr_cnt, viol_cnt;
  logic [7:0] last_wa, last_wd, last_ra;
  logic       prev_wr;

  // monitor: samples 1 time unit after each edge, models the FIFO pop and the register file
  initial begin
    rp = 0; tx_cnt = 0; rdu_cnt = 0; regwr_cnt = 0; regrd_cnt = 0; ferr_cnt = 0; viol_cnt = 0;
    last_wa = 8'h00; last_wd = 8'h00; last_ra = 8'h00; prev_wr = 1'b0;
    bus.rx_empty = 1'b1; bus.r_data = 8'h00; bus.reg_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (bus.rd_uart) begin
        rdu_cnt++;
        if (rp != wp) rp++;
      end
      if (bus.reg_wr) begin
        regwr_cnt++;
        mem[bus.reg_addr] = bus.reg_wdata;
        last_wa = bus.reg_addr;
        last_wd = bus.reg_wdata;
      end
      if (bus.reg_rd) begin
        regrd_cnt++;
        bus.reg_rdata = mem[bus.reg_addr];
        last_ra = bus.reg_addr;
      end
      if (bus.reg_wr && bus.reg_rd) viol_cnt++;
      if (bus.wr_uart) begin
        if (bus.tx_full || prev_wr) viol_cnt++;
        txlog[tx_cnt[9:0]] = bus.w_data;
        tx_cnt++;
      end
      prev_wr = bus.wr_uart;
      if (bus.frame_err) ferr_cnt++;
      bus.rx_empty = (rp == wp);
      bus.r_data   = rx_mem[rp[10:0]];
    end
  end

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] resp;
    int         nbytes;
    int         nwr;
    int         nrd;
  } vec_t;

  vec_t       tbl [10];
  int         n_chk, n_pass;
  int         t0, w0, r0, u0, f0, k, rr, ff, nfr, nw, nr, nb;
  logic [7:0] exp_mem [0:255];
  logic [7:0] exp_q [$];
  logic [7:0] a, d, c;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[wp[10:0]] = b;
    wp++;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_tx(input string nm, input int target, input int budget);
    int i;
    i = 0;
    while (tx_cnt < target && i < budget) begin
      step(1);
      i++;
    end
    chk(nm, tx_cnt, target);
  endtask

  function automatic int outs_all();
    return int'({bus.rd_uart, bus.wr_uart, bus.reg_wr, bus.reg_rd, bus.busy, bus.frame_err,
                 bus.w_data, bus.reg_addr, bus.reg_wdata});
  endfunction

  initial begin
    n_chk = 0; n_pass = 0; wp = 0;
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'h00;
    tbl[0] = '{8'h57, 8'h10, 8'hA5, 8'h4B, 3, 1, 0};
    tbl[1] = '{8'h57, 8'h22, 8'h3C, 8'h4B, 3, 1, 0};
    tbl[2] = '{8'h52, 8'h22, 8'h00, 8'h3C, 2, 0, 1};
    tbl[3] = '{8'h52, 8'h10, 8'h00, 8'hA5, 2, 0, 1};
    tbl[4] = '{8'h41, 8'h00, 8'h00, 8'h3F, 1, 0, 0};
    tbl[5] = '{8'h52, 8'h77, 8'h00, 8'h00, 2, 0, 1};
    tbl[6] = '{8'h00, 8'h00, 8'h00, 8'h3F, 1, 0, 0};
    tbl[7] = '{8'h57, 8'hFF, 8'h00, 8'h4B, 3, 1, 0};
    tbl[8] = '{8'h52, 8'hFF, 8'h00, 8'h00, 2, 0, 1};
    tbl[9] = '{8'h77, 8'h00, 8'h00, 8'h3F, 1, 0, 0};

    reset = 1'b1;
    bus.tx_full = 1'b0;
    step(3);
    chk("reset_outputs", outs_all(), 0);
    reset = 1'b0;
    step(2);

    // frame table
    for (int i = 0; i < 10; i++) begin
      t0 = tx_cnt; w0 = regwr_cnt; r0 = regrd_cnt; u0 = rdu_cnt;
      push(tbl[i].cmd);
      if (tbl[i].nbytes > 1) push(tbl[i].addr);
      if (tbl[i].nbytes > 2) push(tbl[i].data);
      wait_tx($sformatf("v%0d_done", i), t0 + 1, 200);
      chk($sformatf("v%0d_resp", i), int'(txlog[t0[9:0]]), int'(tbl[i].resp));
      chk($sformatf("v%0d_nwr", i), regwr_cnt - w0, tbl[i].nwr);
      chk($sformatf("v%0d_nrd", i), regrd_cnt - r0, tbl[i].nrd);
      chk($sformatf("v%0d_pops", i), rdu_cnt - u0, tbl[i].nbytes);
      chk($sformatf("v%0d_idle", i), int'(bus.busy), 0);
      if (tbl[i].nwr != 0) begin
        chk($sformatf("v%0d_waddr", i), int'(last_wa), int'(tbl[i].addr));
        chk($sformatf("v%0d_wdata", i), int'(last_wd), int'(tbl[i].data));
      end
      if (tbl[i].nrd != 0) chk($sformatf("v%0d_raddr", i), int'(last_ra), int'(tbl[i].addr));
      step(2);
    end

    // write latency: last byte arrives while waiting in GET_DATA
    push(8'h57); push(8'h10);
    step(6);
    push(8'hA5);
    k = 0;
    while (!bus.wr_uart && k < 20) begin step(1); k++; end
    chk("lat_write", k, 4);
    step(1);
    chk("wr_pulse_width", int'(bus.wr_uart), 0);

    // read latency
    t0 = tx_cnt;
    push(8'h52);
    step(4);
    push(8'h22);
    k = 0;
    while (!bus.wr_uart && k < 20) begin step(1); k++; end
    chk("lat_read", k, 5);
    step(1);
    chk("lat_read_resp", int'(txlog[t0[9:0]]), 8'h3C);

    // backpressure during SEND
    t0 = tx_cnt; w0 = regwr_cnt;
    bus.tx_full = 1'b1;
    push(8'h57); push(8'h33); push(8'h5A);
    step(50);
    chk("bp_no_wr", tx_cnt, t0);
    chk("bp_busy", int'(bus.busy), 1);
    chk("bp_reg_wr", regwr_cnt - w0, 1);
    bus.tx_full = 1'b0;
    step(1);
    chk("bp_wr_after", int'(bus.wr_uart), 1);
    chk("bp_resp", int'(bus.w_data), 8'h4B);
    step(3);
    chk("bp_single", tx_cnt - t0, 1);

    // partial frame: timeout or indefinite wait
    t0 = tx_cnt; f0 = ferr_cnt;
`ifdef UART_CMD_TIMEOUT_EN
    push(8'h57);
    k = 0; rr = -1; ff = -1;
    while (ff < 0 && k < 60) begin
      step(1); k++;
      if (bus.rd_uart && rr < 0) rr = k;
      if (bus.frame_err) ff = k;
    end
    chk("to_delay", ff - rr, 8);
    chk("to_busy", int'(bus.busy), 0);
    step(1);
    chk("to_pulse_width", int'(bus.frame_err), 0);
    chk("to_pulses", ferr_cnt - f0, 1);
    chk("to_no_resp", tx_cnt, t0);
`else
    push(8'h57);
    step(40);
    chk("nto_busy", int'(bus.busy), 1);
    chk("nto_no_err", ferr_cnt - f0, 0);
    chk("nto_no_resp", tx_cnt, t0);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
`endif

    // reset in GET_DATA abandons the frame
    push(8'h57); push(8'h10);
    step(5);
    chk("rst_mid_busy", int'(bus.busy), 1);
    w0 = regwr_cnt; r0 = regrd_cnt;
    reset = 1'b1;
    step(1);
    chk("rst_mid_outputs", outs_all(), 0);
    step(2);
    reset = 1'b0;
    t0 = tx_cnt;
    push(8'h52); push(8'h10);
    wait_tx("rst_after_done", t0 + 1, 200);
    chk("rst_after_resp", int'(txlog[t0[9:0]]), 8'hA5);
    chk("rst_after_no_wr", regwr_cnt - w0, 0);
    chk("rst_after_rd", regrd_cnt - r0, 1);
    step(2);

    // random frames streamed back-to-back with random transmit backpressure
    t0 = tx_cnt; w0 = regwr_cnt; r0 = regrd_cnt; u0 = rdu_cnt;
    nfr = 40; nw = 0; nr = 0; nb = 0;
    for (int i = 0; i < nfr; i++) begin
      a = 8'h80 | 8'($urandom_range(0, 63));
      d = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0: begin
          push(8'h57); push(a); push(d); nb += 3; nw++;
          exp_mem[a] = d;
          exp_q.push_back(8'h4B);
        end
        1: begin
          push(8'h52); push(a); nb += 2; nr++;
          exp_q.push_back(exp_mem[a]);
        end
        default: begin
          do c = 8'($urandom_range(0, 255)); while (c == 8'h57 || c == 8'h52);
          push(c); nb += 1;
          exp_q.push_back(8'h3F);
        end
      endcase
    end
    k = 0;
    while (tx_cnt < t0 + nfr && k < 20000) begin
      bus.tx_full = ($urandom_range(0, 3) == 0);
      step(1);
      k++;
    end
    bus.tx_full = 1'b0;
    step(2);
    chk("rnd_count", tx_cnt - t0, nfr);
    for (int i = 0; i < nfr; i++) begin
      t0 = t0 + 0;
      chk($sformatf("rnd_resp%0d", i), int'(txlog[10'(t0 + i)]), int'(exp_q[i]));
    end
    chk("rnd_nwr", regwr_cnt - w0, nw);
    chk("rnd_nrd", regrd_cnt - r0, nr);
    chk("rnd_pops", rdu_cnt - u0, nb);
    chk("protocol_violations", viol_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, sets the inter-byte timeout in clk cycles (used only with UART_CMD_TIMEOUT_EN); legal range 2 to 2^20.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_empty  input  1  UART receive FIFO empty; r_data is valid whenever rx_empty=0 (FIFO head).
REQ-005 r_data  input  8  UART receive FIFO head byte.
REQ-006 rd_uart  output  1  one-cycle pop strobe to the UART receive FIFO.
REQ-007 tx_full  input  1  UART transmit FIFO full.
REQ-008 w_data  output  8  response byte to the UART transmit FIFO.
REQ-009 wr_uart  output  1  one-cycle push strobe to the UART transmit FIFO.
REQ-010 reg_addr  output  8  register bus address.
REQ-011 reg_wdata  output  8  register bus write data.
REQ-012 reg_wr  output  1  one-cycle register write strobe.
REQ-013 reg_rd  output  1  one-cycle register read strobe.
REQ-014 reg_rdata  input  8  register read data, valid exactly one cycle after reg_rd.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 frame_err  output  1  one-cycle pulse on a timed-out partial frame.

Function
REQ-017 The FSM SHALL have the states IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_WAIT and SEND. All outputs SHALL be registered.
REQ-018 A byte SHALL be consumed only in IDLE, GET_ADDR or GET_DATA, and only when rx_empty=0 and rd_uart=0. On that edge r_data SHALL be latched and rd_uart SHALL be set for exactly one cycle.
REQ-019 Transitions out of IDLE on a consumed command byte:
- 0x57 ('W') -> GET_ADDR, write flag set.
- 0x52 ('R') -> GET_ADDR, write flag clear.
- any other value -> SEND with response 0x3F ('?').
REQ-020 Transitions out of GET_ADDR on a consumed byte:
- latch the byte into reg_addr.
- write flag set -> GET_DATA.
- write flag clear -> BUS_RD.
REQ-021 GET_DATA on a consumed byte SHALL latch the byte into reg_wdata and go to BUS_WR.
REQ-022 BUS_WR SHALL assert reg_wr for exactly one cycle, then go to SEND with response 0x4B ('K').
REQ-023 BUS_RD SHALL assert reg_rd for exactly one cycle, then go to RD_WAIT.
REQ-024 RD_WAIT SHALL capture reg_rdata as the response, then go to SEND.
REQ-025 SEND SHALL wait while tx_full=1. On the first cycle with tx_full=0 and wr_uart=0 it SHALL drive w_data=response, pulse wr_uart for one cycle, and return to IDLE. Exactly one response byte SHALL be sent per frame.
REQ-026 reg_addr and reg_wdata SHALL hold their last values between frames. reg_wr and reg_rd SHALL never be high in the same cycle.
REQ-027 Bytes arriving during BUS_WR, BUS_RD, RD_WAIT or SEND SHALL remain in the UART receive FIFO, not be consumed, and be processed after the return to IDLE.
REQ-028 Minimum latency from the push of the last frame byte (FIFO already non-empty) to wr_uart: 4 cycles for a write frame, 5 cycles for a read frame.

Reset
REQ-029 While reset=1, every output SHALL be 0, the FSM SHALL be in IDLE, the response register and write flag SHALL be cleared, and the timeout counter SHALL be cleared.
REQ-030 Reset asserted mid-frame or during SEND SHALL abandon the frame: no reg_wr, reg_rd or wr_uart SHALL be issued for it after reset deasserts.

Configuration
REQ-031 With macro UART_CMD_TIMEOUT_EN defined:
- in GET_ADDR or GET_DATA, a counter SHALL increment each cycle no byte is consumed and SHALL clear on each consumed byte.
- when the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE, pulse frame_err for one cycle, and send no response.
REQ-032 Without UART_CMD_TIMEOUT_EN, no counter SHALL exist, GET_ADDR and GET_DATA SHALL wait indefinitely, and frame_err SHALL be tied to 0.

Verification
REQ-033 Write frame: bytes 0x57, 0x10, 0xA5 in the FIFO -> reg_wr pulse with reg_addr=0x10 and reg_wdata=0xA5, then wr_uart with w_data=0x4B; three rd_uart pulses.
REQ-034 Read frame: bytes 0x52, 0x22, with reg_rdata=0x3C the cycle after reg_rd -> one reg_rd pulse with reg_addr=0x22, then wr_uart with w_data=0x3C.
REQ-035 Unknown command: byte 0x41 -> one rd_uart, then wr_uart with w_data=0x3F, no reg_wr or reg_rd, FSM back in IDLE.
REQ-036 Backpressure: tx_full=1 for 50 cycles during SEND of a write frame -> wr_uart stays low and busy=1; the single wr_uart pulse follows tx_full falling.
REQ-037 Timeout (macro defined, TIMEOUT_CYCLES=8): byte 0x57 then FIFO empty -> frame_err pulse 8 cycles after the rd_uart cycle, busy=0, no wr_uart; without the macro busy stays 1.
REQ-038 Reset in GET_DATA after bytes 0x57 and 0x10 -> all outputs 0; a following frame 0x52, 0x10 executes normally.
